dispatcher: RTL and testbench

Issue stage between the instruction fetch/decode path and the execution back end. It holds one decoded instruction at a time and allocates a ROB entry for it. It resolves both source operands from the register file, the ROB and the three CDBs, and renames the destination register. It then sends one registered issue packet to either the reservation station (ALU ops) or the load/store buffer (memory ops).

---
 rtl/dispatcher.sv | 181 ++++++++++++++++++
 tb/tb_dispatcher.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatcher.sv
// rtl/dispatcher.sv - one-entry issue stage: ROB allocate, operand resolve, rename, issue to RS/LSB
module dispatcher #(
    parameter int OPENUM_W = 6,
    parameter int ROB_ID_W = 4,
    parameter int REG_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                inst_valid_from_dec,
    input  logic [OPENUM_W-1:0] openum_from_dec,
    input  logic [REG_W-1:0]    rd_from_dec,
    input  logic [REG_W-1:0]    rs1_from_dec,
    input  logic [REG_W-1:0]    rs2_from_dec,
    input  logic [31:0]         imm_from_dec,
    input  logic [31:0]         pc_from_dec,
    input  logic                is_ls_from_dec,
    input  logic                has_rd_from_dec,
    output logic                ready_to_dec,
    input  logic                rs_full,
    input  logic                lsb_full,
    input  logic                rob_full,
    input  logic [ROB_ID_W-1:0] rob_free_id,
    output logic                ena_to_rob,
    output logic [OPENUM_W-1:0] openum_to_rob,
    output logic [REG_W-1:0]    rd_to_rob,
    output logic [31:0]         pc_to_rob,
    output logic [REG_W-1:0]    rs1_to_reg,
    output logic [REG_W-1:0]    rs2_to_reg,
    input  logic [31:0]         V1_from_reg,
    input  logic [31:0]         V2_from_reg,
    input  logic [ROB_ID_W-1:0] Q1_from_reg,
    input  logic [ROB_ID_W-1:0] Q2_from_reg,
    output logic                rename_ena_to_reg,
    output logic [REG_W-1:0]    rename_rd_to_reg,
    output logic [ROB_ID_W-1:0] rename_id_to_reg,
    output logic [ROB_ID_W-1:0] Q1_to_rob,
    output logic [ROB_ID_W-1:0] Q2_to_rob,
    input  logic                rob_ready1,
    input  logic                rob_ready2,
    input  logic [31:0]         rob_value1,
    input  logic [31:0]         rob_value2,
    input  logic                valid_from_rs_cdb1,
    input  logic [ROB_ID_W-1:0] rob_id_from_rs_cdb1,
    input  logic [31:0]         result_from_rs_cdb1,
    input  logic                valid_from_rs_cdb2,
    input  logic [ROB_ID_W-1:0] rob_id_from_rs_cdb2,
    input  logic [31:0]         result_from_rs_cdb2,
    input  logic                valid_from_ls_cdb,
    input  logic [ROB_ID_W-1:0] rob_id_from_ls_cdb,
    input  logic [31:0]         result_from_ls_cdb,
    input  logic                rollback_flag_from_rob,
    output logic                ena_to_rs,
    output logic                ena_to_lsb,
    output logic [OPENUM_W-1:0] openum_to_x,
    output logic [31:0]         V1_to_x,
    output logic [31:0]         V2_to_x,
    output logic [ROB_ID_W-1:0] Q1_to_x,
    output logic [ROB_ID_W-1:0] Q2_to_x,
    output logic [31:0]         pc_to_x,
    output logic [31:0]         imm_to_x,
    output logic [ROB_ID_W-1:0] rob_id_to_x
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_HELD  = 1'b1;

    logic [0:0]          state;
    logic [OPENUM_W-1:0] openum_q;
    logic [REG_W-1:0]    rd_q, rs1_q, rs2_q;
    logic [31:0]         imm_q, pc_q;
    logic                is_ls_q, has_rd_q;

    logic                fire, accept;
    logic [ROB_ID_W+31:0] src1, src2;

    // Returns {Q, V}; a non-zero Q means the operand is still pending on that ROB id.
    function automatic logic [ROB_ID_W+31:0] resolve(
        input logic [REG_W-1:0]    rs,
        input logic [31:0]         v_reg,
        input logic [ROB_ID_W-1:0] q_reg,
        input logic                rob_rdy,
        input logic [31:0]         rob_val
    );
        logic [ROB_ID_W+31:0] r;
        if (rs == '0)
            r = '0;
        else if (q_reg == '0)
            r = {{ROB_ID_W{1'b0}}, v_reg};
        else if (rob_rdy)
            r = {{ROB_ID_W{1'b0}}, rob_val};
        else if (valid_from_rs_cdb1 && rob_id_from_rs_cdb1 == q_reg)
            r = {{ROB_ID_W{1'b0}}, result_from_rs_cdb1};
        else if (valid_from_rs_cdb2 && rob_id_from_rs_cdb2 == q_reg)
            r = {{ROB_ID_W{1'b0}}, result_from_rs_cdb2};
        else if (valid_from_ls_cdb && rob_id_from_ls_cdb == q_reg)
            r = {{ROB_ID_W{1'b0}}, result_from_ls_cdb};
        else
            r = {q_reg, 32'd0};
        return r;
    endfunction

    always_comb begin
        fire = rdy && !rollback_flag_from_rob && (state == ST_HELD) && !rob_full &&
               (is_ls_q ? !lsb_full : !rs_full);
        ready_to_dec = rdy && !rollback_flag_from_rob && ((state == ST_EMPTY) || fire);
        accept = inst_valid_from_dec && ready_to_dec;
        src1 = resolve(rs1_q, V1_from_reg, Q1_from_reg, rob_ready1, rob_value1);
        src2 = resolve(rs2_q, V2_from_reg, Q2_from_reg, rob_ready2, rob_value2);
    end

    assign ena_to_rob        = fire;
    assign openum_to_rob     = openum_q;
    assign rd_to_rob         = rd_q;
    assign pc_to_rob         = pc_q;
    assign rs1_to_reg        = rs1_q;
    assign rs2_to_reg        = rs2_q;
    assign Q1_to_rob         = Q1_from_reg;
    assign Q2_to_rob         = Q2_from_reg;
    assign rename_ena_to_reg = fire && has_rd_q && (rd_q != '0);
    assign rename_rd_to_reg  = rd_q;
    assign rename_id_to_reg  = rob_free_id;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_EMPTY;
            ena_to_rs   <= 1'b0;
            ena_to_lsb  <= 1'b0;
            openum_to_x <= '0;
            V1_to_x     <= '0;
            V2_to_x     <= '0;
            Q1_to_x     <= '0;
            Q2_to_x     <= '0;
            pc_to_x     <= '0;
            imm_to_x    <= '0;
            rob_id_to_x <= '0;
            openum_q    <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
            is_ls_q     <= 1'b0;
            has_rd_q    <= 1'b0;
        end else if (rdy) begin
            if (rollback_flag_from_rob) begin
                state      <= ST_EMPTY;
                ena_to_rs  <= 1'b0;
                ena_to_lsb <= 1'b0;
            end else begin
                ena_to_rs  <= fire && !is_ls_q;
                ena_to_lsb <= fire && is_ls_q;
                if (fire) begin
                    openum_to_x <= openum_q;
                    V1_to_x     <= src1[31:0];
                    Q1_to_x     <= src1[ROB_ID_W+31:32];
                    V2_to_x     <= src2[31:0];
                    Q2_to_x     <= src2[ROB_ID_W+31:32];
                    pc_to_x     <= pc_q;
                    imm_to_x    <= imm_q;
                    rob_id_to_x <= rob_free_id;
                end
                // Accepting in a fire cycle refills the slot, so the state stays HELD.
                if (accept) begin
                    state    <= ST_HELD;
                    openum_q <= openum_from_dec;
                    rd_q     <= rd_from_dec;
                    rs1_q    <= rs1_from_dec;
                    rs2_q    <= rs2_from_dec;
                    imm_q    <= imm_from_dec;
                    pc_q     <= pc_from_dec;
                    is_ls_q  <= is_ls_from_dec;
                    has_rd_q <= has_rd_from_dec;
                end else if (fire) begin
                    state <= ST_EMPTY;
                end
            end
        end
    end

endmodule

// File: tb/tb_dispatcher.sv
// tb/tb_dispatcher.sv - directed and random checks of dispatcher against a queue-based reference model
module tb_dispatcher;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm, pc;
        logic        is_ls, has_rd;
    } inst_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    always #5 clk = ~clk;

    logic        inst_valid, is_ls_d, has_rd_d, ready_to_dec;
    logic [5:0]  openum_d;
    logic [4:0]  rd_d, rs1_d, rs2_d;
    logic [31:0] imm_d, pc_d;
    logic        rs_full, lsb_full, rob_full, rollback;
    logic [3:0]  rob_free_id;
    logic        ena_to_rob, rename_ena;
    logic [5:0]  openum_to_rob;
    logic [4:0]  rd_to_rob, rs1_to_reg, rs2_to_reg, rename_rd;
    logic [31:0] pc_to_rob;
    logic [31:0] v1r, v2r, rob_value1, rob_value2;
    logic [3:0]  q1r, q2r, rename_id, q1_to_rob, q2_to_rob;
    logic        rob_ready1, rob_ready2;
    logic        cv[3];
    logic [3:0]  cid[3];
    logic [31:0] cres[3];
    logic        ena_to_rs, ena_to_lsb;
    logic [5:0]  openum_to_x;
    logic [31:0] v1_to_x, v2_to_x, pc_to_x, imm_to_x;
    logic [3:0]  q1_to_x, q2_to_x, rob_id_to_x;

    dispatcher dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .inst_valid_from_dec(inst_valid), .openum_from_dec(openum_d), .rd_from_dec(rd_d),
        .rs1_from_dec(rs1_d), .rs2_from_dec(rs2_d), .imm_from_dec(imm_d), .pc_from_dec(pc_d),
        .is_ls_from_dec(is_ls_d), .has_rd_from_dec(has_rd_d), .ready_to_dec(ready_to_dec),
        .rs_full(rs_full), .lsb_full(lsb_full), .rob_full(rob_full), .rob_free_id(rob_free_id),
        .ena_to_rob(ena_to_rob), .openum_to_rob(openum_to_rob), .rd_to_rob(rd_to_rob), .pc_to_rob(pc_to_rob),
        .rs1_to_reg(rs1_to_reg), .rs2_to_reg(rs2_to_reg),
        .V1_from_reg(v1r), .V2_from_reg(v2r), .Q1_from_reg(q1r), .Q2_from_reg(q2r),
        .rename_ena_to_reg(rename_ena), .rename_rd_to_reg(rename_rd), .rename_id_to_reg(rename_id),
        .Q1_to_rob(q1_to_rob), .Q2_to_rob(q2_to_rob),
        .rob_ready1(rob_ready1), .rob_ready2(rob_ready2), .rob_value1(rob_value1), .rob_value2(rob_value2),
        .valid_from_rs_cdb1(cv[0]), .rob_id_from_rs_cdb1(cid[0]), .result_from_rs_cdb1(cres[0]),
        .valid_from_rs_cdb2(cv[1]), .rob_id_from_rs_cdb2(cid[1]), .result_from_rs_cdb2(cres[1]),
        .valid_from_ls_cdb(cv[2]), .rob_id_from_ls_cdb(cid[2]), .result_from_ls_cdb(cres[2]),
        .rollback_flag_from_rob(rollback),
        .ena_to_rs(ena_to_rs), .ena_to_lsb(ena_to_lsb), .openum_to_x(openum_to_x),
        .V1_to_x(v1_to_x), .V2_to_x(v2_to_x), .Q1_to_x(q1_to_x), .Q2_to_x(q2_to_x),
        .pc_to_x(pc_to_x), .imm_to_x(imm_to_x), .rob_id_to_x(rob_id_to_x)
    );

    int n_vec = 0;
    int n_err = 0;

    inst_t       q[$];
    logic        e_rs = 1'b0, e_lsb = 1'b0;
    logic [5:0]  e_op = '0;
    logic [31:0] e_v1 = '0, e_v2 = '0, e_pc = '0, e_imm = '0;
    logic [3:0]  e_q1 = '0, e_q2 = '0, e_id = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Walk the operand rules in priority order; CDBs are scanned as a priority list.
    function automatic void model_resolve(input logic [4:0] rs, input logic [31:0] vreg, input logic [3:0] qreg,
                                          input logic rr, input logic [31:0] rv,
                                          output logic [31:0] v, output logic [3:0] qo);
        v = 0;
        qo = 0;
        if (rs == 0) return;
        if (qreg == 0) begin v = vreg; return; end
        if (rr) begin v = rv; return; end
        for (int k = 0; k < 3; k++)
            if (cv[k] && cid[k] == qreg) begin v = cres[k]; return; end
        qo = qreg;
    endfunction

    task automatic idle();
        inst_valid = 0; openum_d = 0; rd_d = 0; rs1_d = 0; rs2_d = 0; imm_d = 0; pc_d = 0;
        is_ls_d = 0; has_rd_d = 0; rs_full = 0; lsb_full = 0; rob_full = 0; rollback = 0; rdy = 1;
        rob_free_id = 1; v1r = 0; v2r = 0; q1r = 0; q2r = 0; rob_ready1 = 0; rob_ready2 = 0;
        rob_value1 = 0; rob_value2 = 0;
        for (int k = 0; k < 3; k++) begin cv[k] = 0; cid[k] = 0; cres[k] = 0; end
    endtask

    task automatic offer(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm, input logic [31:0] pc, input logic is_ls, input logic has_rd);
        inst_valid = 1; openum_d = op; rd_d = rd; rs1_d = rs1; rs2_d = rs2;
        imm_d = imm; pc_d = pc; is_ls_d = is_ls; has_rd_d = has_rd;
    endtask

    // Called just after a negedge with inputs set; returns at the next negedge.
    task automatic step();
        inst_t h;
        logic held, fire, ready;
        logic [31:0] v1, v2;
        logic [3:0] o1, o2;
        #1;
        held = (q.size() != 0);
        h = held ? q[0] : '{op: 0, rd: 0, rs1: 0, rs2: 0, imm: 0, pc: 0, is_ls: 0, has_rd: 0};
        fire = 0;
        ready = 0;
        if (rdy && !rollback) begin
            fire = held && !rob_full && (h.is_ls ? !lsb_full : !rs_full);
            ready = !held || fire;
        end
        v1 = 0; v2 = 0; o1 = 0; o2 = 0;
        check("ready_to_dec", ready_to_dec, ready);
        check("ena_to_rob", ena_to_rob, fire);
        check("rename_ena", rename_ena, fire && h.has_rd && h.rd != 0);
        check("Q1_to_rob", q1_to_rob, q1r);
        check("Q2_to_rob", q2_to_rob, q2r);
        if (held) begin
            check("rs1_to_reg", rs1_to_reg, h.rs1);
            check("rs2_to_reg", rs2_to_reg, h.rs2);
        end
        if (fire) begin
            check("openum_to_rob", openum_to_rob, h.op);
            check("rd_to_rob", rd_to_rob, h.rd);
            check("pc_to_rob", pc_to_rob, h.pc);
            check("rename_rd", rename_rd, h.rd);
            check("rename_id", rename_id, rob_free_id);
            model_resolve(h.rs1, v1r, q1r, rob_ready1, rob_value1, v1, o1);
            model_resolve(h.rs2, v2r, q2r, rob_ready2, rob_value2, v2, o2);
        end
        @(posedge clk);
        if (rdy) begin
            if (rollback) begin
                q.delete();
                e_rs = 0;
                e_lsb = 0;
            end else begin
                e_rs = fire && !h.is_ls;
                e_lsb = fire && h.is_ls;
                if (fire) begin
                    e_op = h.op; e_v1 = v1; e_q1 = o1; e_v2 = v2; e_q2 = o2;
                    e_pc = h.pc; e_imm = h.imm; e_id = rob_free_id;
                    void'(q.pop_front());
                end
                if (inst_valid && ready)
                    q.push_back('{op: openum_d, rd: rd_d, rs1: rs1_d, rs2: rs2_d, imm: imm_d, pc: pc_d,
                                  is_ls: is_ls_d, has_rd: has_rd_d});
            end
        end
        #1;
        check("ena_to_rs", ena_to_rs, e_rs);
        check("ena_to_lsb", ena_to_lsb, e_lsb);
        check("openum_to_x", openum_to_x, e_op);
        check("V1_to_x", v1_to_x, e_v1);
        check("Q1_to_x", q1_to_x, e_q1);
        check("V2_to_x", v2_to_x, e_v2);
        check("Q2_to_x", q2_to_x, e_q2);
        check("pc_to_x", pc_to_x, e_pc);
        check("imm_to_x", imm_to_x, e_imm);
        check("rob_id_to_x", rob_id_to_x, e_id);
        @(negedge clk);
    endtask

    initial begin
        idle();
        #2;
        check("rst ena_to_rs", ena_to_rs, 0);
        check("rst ena_to_lsb", ena_to_lsb, 0);
        check("rst ready_to_dec", ready_to_dec, 1);
        check("rst ena_to_rob", ena_to_rob, 0);
        check("rst rob_id_to_x", rob_id_to_x, 0);
        check("rst V1_to_x", v1_to_x, 0);
        @(negedge clk);
        rst = 1;

        // ADDI x1,x0,5
        offer(6'h13, 5'd1, 5'd0, 5'd0, 32'd5, 32'h100, 1'b0, 1'b1);
        step();
        idle();
        rob_free_id = 3;
        step();
        check("addi ena_to_rs", ena_to_rs, 1);
        check("addi V1", v1_to_x, 0);
        check("addi Q1", q1_to_x, 0);
        check("addi imm", imm_to_x, 5);
        check("addi rob_id", rob_id_to_x, 3);
        step();
        check("addi single pulse", ena_to_rs, 0);

        // CDB forwarding, then the same dependency with no broadcast
        for (int rep = 0; rep < 2; rep++) begin
            offer(6'h20, 5'd4, 5'd2, 5'd0, 32'd0, 32'h104, 1'b0, 1'b1);
            step();
            idle();
            rob_free_id = 4;
            q1r = 3; v1r = 32'hdead;
            if (rep == 0) begin cv[1] = 1; cid[1] = 3; cres[1] = 32'h10; end
            step();
            check("fwd V1", v1_to_x, rep == 0 ? 32'h10 : 32'h0);
            check("fwd Q1", q1_to_x, rep == 0 ? 4'd0 : 4'd3);
            idle();
        end

        // LW stalled by lsb_full for three cycles while rs_full toggles
        offer(6'h03, 5'd6, 5'd7, 5'd0, 32'd8, 32'h108, 1'b1, 1'b1);
        step();
        idle();
        for (int c = 0; c < 3; c++) begin
            lsb_full = 1;
            rs_full = c[0];
            step();
            check("lw stall ena_to_lsb", ena_to_lsb, 0);
        end
        lsb_full = 0;
        rs_full = 1;
        rob_free_id = 9;
        step();
        check("lw ena_to_lsb", ena_to_lsb, 1);
        check("lw rob_id", rob_id_to_x, 9);
        idle();
        step();
        check("lw single pulse", ena_to_lsb, 0);

        // back-to-back issue
        for (int i = 0; i < 5; i++) begin
            idle();
            if (i < 3) offer(6'h13, 5'(i + 10), 5'd0, 5'd0, 32'(i), 32'(i * 4), 1'b0, 1'b1);
            rob_free_id = 4'(i + 4);
            step();
            if (i >= 1 && i <= 3) begin
                check("b2b ena_to_rs", ena_to_rs, 1);
                check("b2b rob_id", rob_id_to_x, i + 4);
            end
        end
        check("b2b tail", ena_to_rs, 0);

        // rollback in a fire cycle
        idle();
        offer(6'h13, 5'd3, 5'd0, 5'd0, 32'd1, 32'h200, 1'b0, 1'b1);
        step();
        idle();
        rollback = 1;
        step();
        check("rollback ena_to_rs", ena_to_rs, 0);
        rollback = 0;
        #1;
        check("rollback empty", ready_to_dec, 1);
        check("rollback no alloc", ena_to_rob, 0);
        @(negedge clk);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            idle();
            rdy = ($urandom_range(0, 9) != 0);
            rollback = ($urandom_range(0, 19) == 0);
            rs_full = ($urandom_range(0, 3) == 0);
            lsb_full = ($urandom_range(0, 3) == 0);
            rob_full = ($urandom_range(0, 5) == 0);
            rob_free_id = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 9) < 7)
                offer(6'($urandom), 5'($urandom), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                      ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom,
                      1'($urandom), 1'($urandom));
            v1r = $urandom; v2r = $urandom;
            q1r = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            q2r = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            rob_ready1 = ($urandom_range(0, 3) == 0); rob_value1 = $urandom;
            rob_ready2 = ($urandom_range(0, 3) == 0); rob_value2 = $urandom;
            for (int k = 0; k < 3; k++) begin
                cv[k] = 1'($urandom);
                case ($urandom_range(0, 2))
                    0: cid[k] = q1r;
                    1: cid[k] = q2r;
                    default: cid[k] = 4'($urandom);
                endcase
                cres[k] = $urandom;
            end
            step();
        end

        // asynchronous reset while holding a blocked instruction
        idle();
        offer(6'h13, 5'd5, 5'd0, 5'd0, 32'd7, 32'h300, 1'b0, 1'b1);
        step();
        offer(6'h13, 5'd6, 5'd0, 5'd0, 32'd8, 32'h304, 1'b0, 1'b1);
        step();
        check("pre-reset ena_to_rs", ena_to_rs, 1);
        idle();
        rs_full = 1;
        #2;
        rst = 0;
        #1;
        check("async rst ena_to_rs", ena_to_rs, 0);
        check("async rst ready_to_dec", ready_to_dec, 1);
        check("async rst rob_id_to_x", rob_id_to_x, 0);
        check("async rst imm_to_x", imm_to_x, 0);
        q.delete();
        e_rs = 0; e_lsb = 0; e_op = 0; e_v1 = 0; e_v2 = 0; e_q1 = 0; e_q2 = 0;
        e_pc = 0; e_imm = 0; e_id = 0;
        @(negedge clk);
        rst = 1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
